// File: rtl/utlb_pkg.sv
// Shared types and constants for the uTLB refill path.
package utlb_pkg;

  localparam int unsigned UTLB_ENTRIES = 32;
  localparam int unsigned UTLB_IDX_W   = 5;
  localparam int unsigned UTLB_VPN_W   = 27;
  localparam int unsigned UTLB_PPN_W   = 28;

  typedef enum logic [1:0] {
    StIdle,
    StPtwReq,
    StPtwWait,
    StWrite
  } refill_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [UTLB_IDX_W-1:0] lowest_set(input logic [UTLB_ENTRIES-1:0] vec);
    logic [UTLB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = UTLB_ENTRIES - 1; i >= 0; i--) begin
      if (vec[i]) idx = UTLB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/utlb_victim_sel.sv
// Victim choice: lowest invalid entry first, else the PLRU pick (lowest set bit).
module utlb_victim_sel
  import utlb_pkg::*;
(
  input  logic [UTLB_ENTRIES-1:0] entry_vld,
  input  logic [UTLB_ENTRIES-1:0] plru_iutlb_ref_num,
  output logic [UTLB_IDX_W-1:0]   victim_idx,
  output logic                    use_invalid
);

  always_comb begin
    use_invalid = ~&entry_vld;
    victim_idx  = use_invalid ? lowest_set(~entry_vld) : lowest_set(plru_iutlb_ref_num);
  end

endmodule

// File: rtl/utlb_refill_ctrl.sv
// uTLB refill controller: accepts misses, issues page-table walks, writes the victim entry.
module utlb_refill_ctrl
  import utlb_pkg::*;
#(
  parameter int unsigned ENTRIES   = UTLB_ENTRIES,
  parameter int unsigned VPN_WIDTH = UTLB_VPN_W,
  parameter int unsigned PPN_WIDTH = UTLB_PPN_W
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  miss_req_vld,
  input  logic [VPN_WIDTH-1:0]  miss_req_vpn,
  output logic                  miss_req_rdy,
  input  logic                  flush,
  output logic                  ptw_req_vld,
  output logic [VPN_WIDTH-1:0]  ptw_req_vpn,
  input  logic                  ptw_req_rdy,
  input  logic                  ptw_resp_vld,
  input  logic                  ptw_resp_fault,
  input  logic [PPN_WIDTH-1:0]  ptw_resp_ppn,
  input  logic [ENTRIES-1:0]    plru_iutlb_ref_num,
  output logic                  utlb_plru_refill_on,
  output logic                  utlb_plru_refill_vld,
  output logic [ENTRIES-1:0]    entry_vld,
  output logic                  refill_wen,
  output logic [UTLB_IDX_W-1:0] refill_idx,
  output logic [VPN_WIDTH-1:0]  refill_vpn,
  output logic [PPN_WIDTH-1:0]  refill_ppn,
  output logic                  miss_done_vld,
  output logic                  miss_done_fault
);

  refill_state_e          state_q;
  logic [VPN_WIDTH-1:0]   vpn_q;
  logic [PPN_WIDTH-1:0]   ppn_q;
  logic                   kill_q;
  logic                   done_vld_q;
  logic                   done_fault_q;
  logic [ENTRIES-1:0]     entry_vld_q;
  logic [UTLB_IDX_W-1:0]  victim_idx;
  logic                   victim_use_invalid;
  logic                   kill_now;

  utlb_victim_sel u_victim_sel (
    .entry_vld          (entry_vld_q),
    .plru_iutlb_ref_num (plru_iutlb_ref_num),
    .victim_idx         (victim_idx),
    .use_invalid        (victim_use_invalid)
  );

  // A flush in the response cycle kills the walk just like an earlier one.
  assign kill_now = kill_q | flush;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state_q      <= StIdle;
      vpn_q        <= '0;
      ppn_q        <= '0;
      kill_q       <= 1'b0;
      done_vld_q   <= 1'b0;
      done_fault_q <= 1'b0;
      entry_vld_q  <= '0;
    end else begin
      done_vld_q   <= 1'b0;
      done_fault_q <= 1'b0;
      // Replacing an already-valid entry leaves the valid vector unchanged.
      if (flush) begin
        entry_vld_q <= '0;
      end else if (state_q == StWrite && victim_use_invalid) begin
        entry_vld_q[victim_idx] <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          kill_q <= 1'b0;
          if (miss_req_vld) begin
            vpn_q   <= miss_req_vpn;
            state_q <= StPtwReq;
          end
        end
        StPtwReq: begin
          if (flush) kill_q <= 1'b1;
          if (ptw_req_rdy) state_q <= StPtwWait;
        end
        StPtwWait: begin
          if (flush) kill_q <= 1'b1;
          if (ptw_resp_vld) begin
            ppn_q      <= ptw_resp_ppn;
            done_vld_q <= 1'b1;
            if (ptw_resp_fault || kill_now) begin
              done_fault_q <= ptw_resp_fault & ~kill_now;
              state_q      <= StIdle;
            end else begin
              state_q <= StWrite;
            end
          end
        end
        StWrite: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    miss_req_rdy         = (state_q == StIdle);
    ptw_req_vld          = (state_q == StPtwReq);
    ptw_req_vpn          = vpn_q;
    utlb_plru_refill_on  = (state_q != StIdle);
    refill_wen           = (state_q == StWrite) & ~flush;
    utlb_plru_refill_vld = refill_wen;
    refill_idx           = (state_q == StWrite) ? victim_idx : '0;
    refill_vpn           = vpn_q;
    refill_ppn           = ppn_q;
    entry_vld            = entry_vld_q;
    miss_done_vld        = done_vld_q;
    miss_done_fault      = done_fault_q;
  end

endmodule

// File: tb/tb_utlb_refill_ctrl.sv
// Randomized self-checking bench for utlb_refill_ctrl against a behavioural victim model.
module tb_utlb_refill_ctrl;

  logic        clk;
  logic        cpurst;
  logic        miss_req_vld;
  logic [26:0] miss_req_vpn;
  logic        miss_req_rdy;
  logic        flush;
  logic        ptw_req_vld;
  logic [26:0] ptw_req_vpn;
  logic        ptw_req_rdy;
  logic        ptw_resp_vld;
  logic        ptw_resp_fault;
  logic [27:0] ptw_resp_ppn;
  logic [31:0] plru;
  logic        refill_on;
  logic        refill_vld;
  logic [31:0] entry_vld;
  logic        refill_wen;
  logic [4:0]  refill_idx;
  logic [26:0] refill_vpn;
  logic [27:0] refill_ppn;
  logic        miss_done_vld;
  logic        miss_done_fault;

  int          checks;
  int          failures;
  logic [31:0] mvalid;

  typedef struct {
    logic        wen1, plvld1, done1, dfault1, rdy1, extra2, rdy2;
    logic [4:0]  idx1;
    logic [26:0] vpn1;
    logic [27:0] ppn1;
    logic [31:0] ev_flush, ev2;
    int          hold_bad;
  } obs_t;

  utlb_refill_ctrl dut (
    .forever_cpuclk       (clk),
    .cpurst               (cpurst),
    .miss_req_vld         (miss_req_vld),
    .miss_req_vpn         (miss_req_vpn),
    .miss_req_rdy         (miss_req_rdy),
    .flush                (flush),
    .ptw_req_vld          (ptw_req_vld),
    .ptw_req_vpn          (ptw_req_vpn),
    .ptw_req_rdy          (ptw_req_rdy),
    .ptw_resp_vld         (ptw_resp_vld),
    .ptw_resp_fault       (ptw_resp_fault),
    .ptw_resp_ppn         (ptw_resp_ppn),
    .plru_iutlb_ref_num   (plru),
    .utlb_plru_refill_on  (refill_on),
    .utlb_plru_refill_vld (refill_vld),
    .entry_vld            (entry_vld),
    .refill_wen           (refill_wen),
    .refill_idx           (refill_idx),
    .refill_vpn           (refill_vpn),
    .refill_ppn           (refill_ppn),
    .miss_done_vld        (miss_done_vld),
    .miss_done_fault      (miss_done_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Victim rule: first hole, else lowest PLRU bit, else entry 0.
  function automatic int model_victim(input logic [31:0] v, input logic [31:0] p);
    for (int i = 0; i < 32; i++) if (!v[i]) return i;
    for (int i = 0; i < 32; i++) if (p[i]) return i;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one miss through the walker handshake and records what the DUT did.
  task automatic run_miss(input logic [26:0] vpn, input logic [27:0] ppn, input logic fault,
                          input int rdy_dly, input int resp_dly, input int flush_mode,
                          output obs_t o);
    o.hold_bad = 0;
    o.ev_flush = '0;
    miss_req_vld = 1'b1;
    miss_req_vpn = vpn;
    step();
    miss_req_vld = 1'b0;
    miss_req_vpn = 27'($urandom);
    repeat (rdy_dly) begin
      if (ptw_req_vld !== 1'b1 || ptw_req_vpn !== vpn || miss_req_rdy !== 1'b0) o.hold_bad++;
      miss_req_vld = 1'b1;
      step();
    end
    ptw_req_rdy = 1'b1;
    step();
    ptw_req_rdy  = 1'b0;
    miss_req_vld = 1'b0;
    if (flush_mode == 1) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
      o.ev_flush = entry_vld;
    end
    repeat (resp_dly) step();
    ptw_resp_vld   = 1'b1;
    ptw_resp_fault = fault;
    ptw_resp_ppn   = ppn;
    step();
    ptw_resp_vld   = 1'b0;
    ptw_resp_fault = 1'b0;
    ptw_resp_ppn   = 28'($urandom);
    if (flush_mode == 2) begin
      flush = 1'b1;
      #1;
    end
    o.wen1    = refill_wen;
    o.plvld1  = refill_vld;
    o.done1   = miss_done_vld;
    o.dfault1 = miss_done_fault;
    o.rdy1    = miss_req_rdy;
    o.idx1    = refill_idx;
    o.vpn1    = refill_vpn;
    o.ppn1    = refill_ppn;
    step();
    flush    = 1'b0;
    o.extra2 = refill_wen | refill_vld | miss_done_vld;
    o.rdy2   = miss_req_rdy;
    o.ev2    = entry_vld;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    cpurst = 1'b1;
    step();
    got = {miss_req_rdy, ptw_req_vld, refill_on, refill_vld, refill_wen, miss_done_vld,
           miss_done_fault};
    checks++;
    if (got !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=%b", got, 7'b1000000);
    end
    checks++;
    if ({entry_vld, refill_idx, refill_vpn, refill_ppn, ptw_req_vpn} !== '0) begin
      failures++;
      $display("FAIL reset_data got vld=%h idx=%0d vpn=%h ppn=%h pvpn=%h exp=all zero",
               entry_vld, refill_idx, refill_vpn, refill_ppn, ptw_req_vpn);
    end
    cpurst = 1'b0;
    step();
    checks++;
    if (miss_req_rdy !== 1'b1 || entry_vld !== '0) begin
      failures++;
      $display("FAIL reset_release got rdy=%b vld=%h exp rdy=1 vld=0", miss_req_rdy, entry_vld);
    end
    mvalid = '0;
  endtask

  task automatic test_fill();
    obs_t o;
    logic [26:0] vpn;
    logic [27:0] ppn;
    int exp;
    int pulses = 0;
    for (int i = 0; i < 32; i++) begin
      plru = $urandom;
      vpn  = 27'($urandom);
      ppn  = 28'($urandom);
      exp  = model_victim(mvalid, plru);
      run_miss(vpn, ppn, 1'b0, 0, 0, 0, o);
      mvalid[exp] = 1'b1;
      if (o.plvld1 === 1'b1) pulses++;
      checks++;
      if ({o.wen1, o.plvld1, o.done1, o.dfault1} !== 4'b1110) begin
        failures++;
        $display("FAIL fill_strobes i=%0d got=%b exp=1110", i, {o.wen1, o.plvld1, o.done1,
                 o.dfault1});
      end
      checks++;
      if (o.idx1 !== 5'(exp) || o.idx1 !== 5'(i)) begin
        failures++;
        $display("FAIL fill_idx got=%0d exp=%0d", o.idx1, i);
      end
      checks++;
      if (o.vpn1 !== vpn || o.ppn1 !== ppn) begin
        failures++;
        $display("FAIL fill_data got=%h/%h exp=%h/%h", o.vpn1, o.ppn1, vpn, ppn);
      end
      checks++;
      if (o.rdy2 !== 1'b1 || o.extra2 !== 1'b0 || o.ev2 !== mvalid) begin
        failures++;
        $display("FAIL fill_after got rdy=%b extra=%b vld=%h exp rdy=1 extra=0 vld=%h",
                 o.rdy2, o.extra2, o.ev2, mvalid);
      end
    end
    checks++;
    if (pulses != 32) begin
      failures++;
      $display("FAIL fill_pulses got=%0d exp=32", pulses);
    end
    checks++;
    if (entry_vld !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL fill_full got=%h exp=ffffffff", entry_vld);
    end
  endtask

  task automatic test_plru_victim();
    obs_t o;
    logic [31:0] pv [7];
    int exp;
    pv[0] = 32'h0001_0000;
    pv[1] = 32'h0000_0000;
    pv[2] = 32'h0000_0A00;
    pv[3] = 32'h1 << $urandom_range(31, 0);
    pv[4] = 32'h1 << $urandom_range(31, 0);
    pv[5] = $urandom;
    pv[6] = $urandom;
    for (int k = 0; k < 7; k++) begin
      plru = pv[k];
      exp  = model_victim(mvalid, plru);
      run_miss(27'($urandom), 28'($urandom), 1'b0, 0, 0, 0, o);
      checks++;
      if (o.idx1 !== 5'(exp) || o.wen1 !== 1'b1 || o.ev2 !== 32'hFFFF_FFFF) begin
        failures++;
        $display("FAIL plru_victim plru=%h got idx=%0d wen=%b vld=%h exp idx=%0d wen=1 vld=ffffffff",
                 plru, o.idx1, o.wen1, o.ev2, exp);
      end
    end
  endtask

  task automatic test_hole();
    obs_t o;
    int exp;
    int k;
    for (int round = 0; round < 2; round++) begin
      flush = 1'b1;
      step();
      flush  = 1'b0;
      mvalid = '0;
      checks++;
      if (entry_vld !== '0) begin
        failures++;
        $display("FAIL hole_flush got=%h exp=0", entry_vld);
      end
      k = (round == 0) ? 7 : $urandom_range(31, 1);
      for (int i = 0; i < k; i++) begin
        plru = $urandom;
        exp  = model_victim(mvalid, plru);
        run_miss(27'($urandom), 28'($urandom), 1'b0, 0, 0, 0, o);
        mvalid[exp] = 1'b1;
      end
      plru = 32'h8000_0000;
      exp  = model_victim(mvalid, plru);
      run_miss(27'($urandom), 28'($urandom), 1'b0, 0, 0, 0, o);
      mvalid[exp] = 1'b1;
      checks++;
      if (o.idx1 !== 5'(exp) || exp != k) begin
        failures++;
        $display("FAIL hole_idx got=%0d exp=%0d", o.idx1, k);
      end
    end
  endtask

  task automatic test_fault();
    obs_t o;
    for (int n = 0; n < 3; n++) begin
      plru = $urandom;
      run_miss(27'($urandom), 28'($urandom), 1'b1, $urandom_range(2, 0),
               $urandom_range(2, 0), 0, o);
      checks++;
      if ({o.wen1, o.plvld1, o.done1, o.dfault1, o.rdy1} !== 5'b00111) begin
        failures++;
        $display("FAIL fault_resp got=%b exp=00111", {o.wen1, o.plvld1, o.done1, o.dfault1,
                 o.rdy1});
      end
      checks++;
      if (o.ev2 !== mvalid || o.extra2 !== 1'b0) begin
        failures++;
        $display("FAIL fault_state got vld=%h extra=%b exp vld=%h extra=0", o.ev2, o.extra2,
                 mvalid);
      end
    end
  endtask

  task automatic test_flush();
    obs_t o;
    int exp;
    while (mvalid != 32'hFFFF_FFFF) begin
      plru = $urandom;
      exp  = model_victim(mvalid, plru);
      run_miss(27'($urandom), 28'($urandom), 1'b0, 0, 0, 0, o);
      mvalid[exp] = 1'b1;
    end
    for (int f = 0; f < 2; f++) begin
      run_miss(27'($urandom), 28'($urandom), f[0], 0, 2, 1, o);
      mvalid = '0;
      checks++;
      if (o.ev_flush !== '0) begin
        failures++;
        $display("FAIL flush_wait_vld got=%h exp=0", o.ev_flush);
      end
      checks++;
      if ({o.wen1, o.plvld1, o.done1, o.dfault1} !== 4'b0010 || o.ev2 !== '0) begin
        failures++;
        $display("FAIL flush_wait_drop got=%b vld=%h exp=0010 vld=0",
                 {o.wen1, o.plvld1, o.done1, o.dfault1}, o.ev2);
      end
    end
    for (int i = 0; i < 3; i++) begin
      plru = $urandom;
      exp  = model_victim(mvalid, plru);
      run_miss(27'($urandom), 28'($urandom), 1'b0, 0, 0, 0, o);
      mvalid[exp] = 1'b1;
    end
    run_miss(27'($urandom), 28'($urandom), 1'b0, 1, 1, 2, o);
    mvalid = '0;
    checks++;
    if ({o.wen1, o.plvld1, o.done1, o.dfault1} !== 4'b0010 || o.ev2 !== '0) begin
      failures++;
      $display("FAIL flush_write got=%b vld=%h exp=0010 vld=0",
               {o.wen1, o.plvld1, o.done1, o.dfault1}, o.ev2);
    end
    plru = $urandom;
    run_miss(27'($urandom), 28'($urandom), 1'b0, 0, 0, 0, o);
    mvalid[0] = 1'b1;
    checks++;
    if (o.wen1 !== 1'b1 || o.idx1 !== 5'd0 || o.ev2 !== 32'h1) begin
      failures++;
      $display("FAIL flush_recover got wen=%b idx=%0d vld=%h exp wen=1 idx=0 vld=1",
               o.wen1, o.idx1, o.ev2);
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    logic [26:0] vpn;
    int exp;
    vpn  = 27'($urandom);
    plru = $urandom;
    exp  = model_victim(mvalid, plru);
    run_miss(vpn, 28'($urandom), 1'b0, 5, 1, 0, o);
    mvalid[exp] = 1'b1;
    checks++;
    if (o.hold_bad != 0) begin
      failures++;
      $display("FAIL bp_hold got=%0d bad cycles exp=0", o.hold_bad);
    end
    checks++;
    if (o.wen1 !== 1'b1 || o.vpn1 !== vpn || o.idx1 !== 5'(exp)) begin
      failures++;
      $display("FAIL bp_write got wen=%b vpn=%h idx=%0d exp wen=1 vpn=%h idx=%0d",
               o.wen1, o.vpn1, o.idx1, vpn, exp);
    end
  endtask

  task automatic test_reset_midop();
    logic [6:0] got;
    int bad = 0;
    miss_req_vld = 1'b1;
    miss_req_vpn = 27'($urandom);
    step();
    miss_req_vld = 1'b0;
    ptw_req_rdy  = 1'b1;
    step();
    ptw_req_rdy = 1'b0;
    #2;
    cpurst = 1'b1;
    #1;
    got = {miss_req_rdy, ptw_req_vld, refill_on, refill_vld, refill_wen, miss_done_vld,
           miss_done_fault};
    checks++;
    if (got !== 7'b1000000 || entry_vld !== '0 || refill_vpn !== '0 || ptw_req_vpn !== '0) begin
      failures++;
      $display("FAIL midop_reset got=%b vld=%h vpn=%h exp=1000000 vld=0 vpn=0",
               got, entry_vld, refill_vpn);
    end
    mvalid = '0;
    step();
    cpurst = 1'b0;
    ptw_resp_vld = 1'b1;
    ptw_resp_ppn = 28'($urandom);
    step();
    ptw_resp_vld = 1'b0;
    repeat (3) begin
      if (refill_wen !== 1'b0 || miss_done_vld !== 1'b0 || miss_req_rdy !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0 || entry_vld !== '0) begin
      failures++;
      $display("FAIL midop_resp_ignored got bad=%0d vld=%h exp bad=0 vld=0", bad, entry_vld);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [26:0] vpn;
    logic [27:0] ppn;
    logic fault;
    int exp;
    int bad = 0;
    for (int n = 0; n < 50; n++) begin
      plru  = ($urandom_range(1, 0) == 1) ? (32'h1 << $urandom_range(31, 0)) : $urandom;
      vpn   = 27'($urandom);
      ppn   = 28'($urandom);
      fault = ($urandom_range(4, 0) == 0);
      exp   = model_victim(mvalid, plru);
      run_miss(vpn, ppn, fault, $urandom_range(3, 0), $urandom_range(3, 0), 0, o);
      if (!fault) mvalid[exp] = 1'b1;
      if (o.wen1 !== !fault || o.done1 !== 1'b1 || o.dfault1 !== fault || o.ev2 !== mvalid ||
          (!fault && (o.idx1 !== 5'(exp) || o.vpn1 !== vpn || o.ppn1 !== ppn))) begin
        bad++;
        $display("FAIL b2b n=%0d got wen=%b idx=%0d flt=%b vld=%h exp wen=%b idx=%0d flt=%b vld=%h",
                 n, o.wen1, o.idx1, o.dfault1, o.ev2, !fault, exp, fault, mvalid);
      end
      checks++;
      if (bad != 0) begin
        failures++;
        bad = 0;
      end
      if (n == 24) begin
        flush = 1'b1;
        step();
        flush  = 1'b0;
        mvalid = '0;
      end
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    mvalid         = '0;
    cpurst         = 1'b1;
    miss_req_vld   = 1'b0;
    miss_req_vpn   = '0;
    flush          = 1'b0;
    ptw_req_rdy    = 1'b0;
    ptw_resp_vld   = 1'b0;
    ptw_resp_fault = 1'b0;
    ptw_resp_ppn   = '0;
    plru           = '0;
    test_reset();
    test_fill();
    test_plru_victim();
    test_hole();
    test_fault();
    test_flush();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
